// File: rtl/imm_branch_gen_pipe.sv
// imm_branch_gen_pipe
// Immediate extension plus branch/jump target generation at the ID/EX
// boundary. Results are registered with valid tracking, stall (hold) and
// flush (bubble) control. LAT selects a 1- or 2-stage pipeline; in the
// 2-stage form the target adder and jump concatenation sit between the
// stage-1 and stage-2 registers.

module imm_branch_gen_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int SHIFT  = 2,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        ext_op,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [DATA_W-1:0] pc_plus,
    output logic              out_valid,
    output logic [DATA_W-1:0] immout,
    output logic [DATA_W-1:0] conba,
    output logic [DATA_W-1:0] jta
);

    localparam int PAD_W = DATA_W - IMM_W;
    localparam int JLO_W = JIDX_W + SHIFT;

    // ------------------------------------------------------------------
    // Extension / target helpers
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] sext_f(input logic [IMM_W-1:0] v);
        return {{PAD_W{v[IMM_W-1]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext_f(input logic [IMM_W-1:0] v);
        return {{PAD_W{1'b0}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] lui_f(input logic [IMM_W-1:0] v);
        return {v, {PAD_W{1'b0}}};
    endfunction

    // ext_op 2'b11 is an alias of sign-extend
    function automatic logic [DATA_W-1:0] ext_f(input logic [1:0] op,
                                                 input logic [IMM_W-1:0] v);
        logic [DATA_W-1:0] r;
        case (op)
            2'b00:   r = zext_f(v);
            2'b01:   r = sext_f(v);
            2'b10:   r = lui_f(v);
            2'b11:   r = sext_f(v);
            default: r = sext_f(v);
        endcase
        return r;
    endfunction

    // Upper PC bits (if any) above the shifted jump index
    function automatic logic [DATA_W-1:0] jta_f(input logic [DATA_W-1:0] pc,
                                                 input logic [JIDX_W-1:0] ji);
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] r;
        lo = DATA_W'(ji) << SHIFT;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < JLO_W) begin
                r[i] = lo[i];
            end else begin
                r[i] = pc[i];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage-1 combinational front end
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ext_s;
    logic [DATA_W-1:0] off_s;

    // Extended immediate and word-scaled branch offset (always sign-extended)
    always_comb begin
        ext_s = ext_f(ext_op, imm);
        off_s = sext_f(imm) << SHIFT;
    end

    // ------------------------------------------------------------------
    // Pipeline body
    // ------------------------------------------------------------------
    generate
        if (LAT == 1) begin : g_lat1
            logic              v_r;
            logic [DATA_W-1:0] imm_r;
            logic [DATA_W-1:0] conba_r;
            logic [DATA_W-1:0] jta_r;
            logic [DATA_W-1:0] conba_s;
            logic [DATA_W-1:0] jta_s;

            // Target computation feeding the single output stage
            always_comb begin
                conba_s = pc_plus + off_s;
                jta_s   = jta_f(pc_plus, jidx);
            end

            // Single stage: flush beats stall beats load; data loads only on valid
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_r     <= 1'b0;
                    imm_r   <= {DATA_W{1'b0}};
                    conba_r <= {DATA_W{1'b0}};
                    jta_r   <= {DATA_W{1'b0}};
                end else if (flush) begin
                    v_r <= 1'b0;
                end else if (stall) begin
                    v_r <= v_r;
                end else begin
                    v_r <= in_valid;
                    if (in_valid) begin
                        imm_r   <= ext_s;
                        conba_r <= conba_s;
                        jta_r   <= jta_s;
                    end
                end
            end

            assign out_valid = v_r;
            assign immout    = imm_r;
            assign conba     = conba_r;
            assign jta       = jta_r;
        end else if (LAT == 2) begin : g_lat2
            logic              v1_r;
            logic [DATA_W-1:0] imm1_r;
            logic [DATA_W-1:0] off1_r;
            logic [DATA_W-1:0] pc1_r;
            logic [JIDX_W-1:0] jidx1_r;
            logic              v2_r;
            logic [DATA_W-1:0] imm2_r;
            logic [DATA_W-1:0] conba2_r;
            logic [DATA_W-1:0] jta2_r;
            logic [DATA_W-1:0] conba_s;
            logic [DATA_W-1:0] jta_s;

            // Stage 1: capture extended immediate, scaled offset, pc and index
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v1_r    <= 1'b0;
                    imm1_r  <= {DATA_W{1'b0}};
                    off1_r  <= {DATA_W{1'b0}};
                    pc1_r   <= {DATA_W{1'b0}};
                    jidx1_r <= {JIDX_W{1'b0}};
                end else if (flush) begin
                    v1_r <= 1'b0;
                end else if (stall) begin
                    v1_r <= v1_r;
                end else begin
                    v1_r <= in_valid;
                    if (in_valid) begin
                        imm1_r  <= ext_s;
                        off1_r  <= off_s;
                        pc1_r   <= pc_plus;
                        jidx1_r <= jidx;
                    end
                end
            end

            // Adder and jump concatenation between the two stages
            always_comb begin
                conba_s = pc1_r + off1_r;
                jta_s   = jta_f(pc1_r, jidx1_r);
            end

            // Stage 2: register final results when stage 1 holds a live entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2_r     <= 1'b0;
                    imm2_r   <= {DATA_W{1'b0}};
                    conba2_r <= {DATA_W{1'b0}};
                    jta2_r   <= {DATA_W{1'b0}};
                end else if (flush) begin
                    v2_r <= 1'b0;
                end else if (stall) begin
                    v2_r <= v2_r;
                end else begin
                    v2_r <= v1_r;
                    if (v1_r) begin
                        imm2_r   <= imm1_r;
                        conba2_r <= conba_s;
                        jta2_r   <= jta_s;
                    end
                end
            end

            assign out_valid = v2_r;
            assign immout    = imm2_r;
            assign conba     = conba2_r;
            assign jta       = jta2_r;
        end else begin : g_bad_lat
            $error("imm_branch_gen_pipe: LAT must be 1 or 2");
        end
    endgenerate

endmodule
